// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store funct3
// encodings (also used by the core decode stage) and the responder FSM state.
package dmem_responder_pkg;

    // Load width/sign codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store width codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data-memory responder: store byte enables and
// read-modify-write merge, load lane extraction with sign/zero extension,
// and funct3 / alignment fault detection.
// Build option: define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word
// accesses; otherwise the offending low address bits are masked.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    output logic        err,
    output logic        wr_en,
    output logic [31:0] wr_word,
    output logic [31:0] rd_data
);

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP_MISALIGN = 1'b1;
`else
    localparam bit TRAP_MISALIGN = 1'b0;
`endif

    logic [3:0]  be;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Decode width, build byte enables / load result, and flag illegal accesses.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        err     = 1'b0;
        be      = 4'b0000;
        st_data = 32'h0;
        rd_data = 32'h0;
        ld_byte = 8'(old_word >> {addr_lo, 3'b000});
        ld_half = addr_lo[1] ? old_word[31:16] : old_word[15:0];

        if (we) begin
            case (funct3)
                F3_SB: begin
                    be      = 4'b0001 << addr_lo;
                    st_data = {4{wdata[7:0]}};
                end
                F3_SH: begin
                    if (TRAP_MISALIGN && addr_lo[0]) err = 1'b1;
                    be      = addr_lo[1] ? 4'b1100 : 4'b0011;
                    st_data = {2{wdata[15:0]}};
                end
                F3_SW: begin
                    if (TRAP_MISALIGN && (addr_lo != 2'b00)) err = 1'b1;
                    be      = 4'b1111;
                    st_data = wdata;
                end
                default: err = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_LB:  rd_data = {{24{ld_byte[7]}}, ld_byte};
                F3_LBU: rd_data = {24'h0, ld_byte};
                F3_LH: begin
                    if (TRAP_MISALIGN && addr_lo[0]) err = 1'b1;
                    rd_data = {{16{ld_half[15]}}, ld_half};
                end
                F3_LHU: begin
                    if (TRAP_MISALIGN && addr_lo[0]) err = 1'b1;
                    rd_data = {16'h0, ld_half};
                end
                F3_LW: begin
                    if (TRAP_MISALIGN && (addr_lo != 2'b00)) err = 1'b1;
                    rd_data = old_word;
                end
                default: err = 1'b1;
            endcase
        end

        // Faulted accesses return zero and never write.
        if (err) rd_data = 32'h0;
    end

    // Merge enabled store bytes into the current word; untouched lanes keep old data.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wr_word[8*i +: 8] = be[i] ? st_data[8*i +: 8] : old_word[8*i +: 8];
        end
    end

    assign wr_en = we && !err;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the core MEM stage: one request
// outstanding, WAIT_CYCLES wait states, then a held response until taken.
// Build option: DMEM_MISALIGN_TRAP_EN (handled in dmem_lane_align).
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    import dmem_responder_pkg::*;

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      mem [DEPTH_WORDS];

    state_t           state;
    logic [3:0]       count;
    logic             cap_we;
    logic [IDX_W-1:0] cap_idx;
    logic [1:0]       cap_lo;
    logic [31:0]      cap_wdata;
    logic [2:0]       cap_funct3;

    logic             accept;
    logic             commit;
    logic             acc_we;
    logic [IDX_W-1:0] acc_idx;
    logic [1:0]       acc_lo;
    logic [31:0]      acc_wdata;
    logic [2:0]       acc_funct3;
    logic             acc_err;
    logic             wr_en;
    logic [31:0]      wr_word;
    logic [31:0]      rd_data;

    // Address bits above the word index wrap around and are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:IDX_W+2];

    assign accept = (state == ST_IDLE) && req_valid && req_ready;

    // With no wait states the access happens on the accepting edge itself,
    // so it must read the live request rather than the captured copy.
    assign commit = (accept && (WAIT_CYCLES == 0)) ||
                    ((state == ST_WAIT) && (count == 4'd0));

    assign acc_we     = (state == ST_IDLE) ? req_we                   : cap_we;
    assign acc_idx    = (state == ST_IDLE) ? req_addr[IDX_W+1:2]      : cap_idx;
    assign acc_lo     = (state == ST_IDLE) ? req_addr[1:0]            : cap_lo;
    assign acc_wdata  = (state == ST_IDLE) ? req_wdata                : cap_wdata;
    assign acc_funct3 = (state == ST_IDLE) ? req_funct3               : cap_funct3;

    dmem_lane_align u_align (
        .we       (acc_we),
        .funct3   (acc_funct3),
        .addr_lo  (acc_lo),
        .wdata    (acc_wdata),
        .old_word (mem[acc_idx]),
        .err      (acc_err),
        .wr_en    (wr_en),
        .wr_word  (wr_word),
        .rd_data  (rd_data)
    );

    // Storage write on the commit edge only.
    // NOTE: the array has no reset branch; clearing it would cost a full-depth
    // reset network and prevent mapping onto RAM, and software never relies on it.
    always_ff @(posedge clk) begin
        if (commit && wr_en) mem[acc_idx] <= wr_word;
    end

    // Request/response FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state      <= ST_IDLE;
            count      <= 4'd0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_err    <= 1'b0;
            cap_we     <= 1'b0;
            cap_idx    <= '0;
            cap_lo     <= 2'b00;
            cap_wdata  <= 32'h0;
            cap_funct3 <= 3'b000;
        end else begin
            if (commit) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= acc_we ? 32'h0 : rd_data;
                rsp_err   <= acc_err;
            end

            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready  <= 1'b0;
                        cap_we     <= req_we;
                        cap_idx    <= req_addr[IDX_W+1:2];
                        cap_lo     <= req_addr[1:0];
                        cap_wdata  <= req_wdata;
                        cap_funct3 <= req_funct3;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            count <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (count == 4'd0) state <= ST_RESP;
                    else               count <= count - 4'd1;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (WAIT_CYCLES = 2, DEPTH_WORDS = 1024).
// Expected responses are queued when a request is driven and compared when
// the response appears.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int WAIT_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [2:0]  req_funct3 = 3'b000;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for req_ready at a falling edge, then present a request
    // and let the next rising edge accept it.
    task automatic drive_req(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [2:0] f3);
        int guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Full transaction: queue expectation, accept, measure latency (the
    // accepting edge counts as edge 1), compare, optionally stall, handshake.
    task automatic issue(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3,
                         input logic [31:0] exp_rdata, input logic exp_err, input int stall);
        exp_t        e;
        int          lat;
        logic [31:0] held;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb_q.push_back(e);
        drive_req(tag, we, addr, wdata, f3);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(WAIT_CYCLES + 1));
        e = sb_q.pop_front();
        if (rsp_valid) begin
            check({tag, ".rdata"}, rsp_rdata, e.rdata);
            check({tag, ".err"}, 32'(rsp_err), 32'(e.err));
            held = rsp_rdata;
            for (int i = 0; i < stall; i++) begin
                // A competing store must be ignored while the response is held.
                req_valid  = 1'b1;
                req_we     = 1'b1;
                req_addr   = 32'h10;
                req_wdata  = 32'h0BAD0BAD;
                req_funct3 = F3_SW;
                @(posedge clk);
                #1;
                check({tag, ".stall_valid"}, 32'(rsp_valid), 32'd1);
                check({tag, ".stall_rdata"}, rsp_rdata, held);
                check({tag, ".stall_ready"}, 32'(req_ready), 32'd0);
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
            check({tag, ".drop_valid"}, 32'(rsp_valid), 32'd0);
            check({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
        end
    endtask

    logic [31:0] rnd_word;
    logic [31:0] rnd_addr;
    logic [31:0] word10;

    initial begin
        // Reset values while rst_n is low
        #12;
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_rdata", rsp_rdata, 32'h0);
        check("rst.rsp_err", 32'(rsp_err), 32'd0);
        check("rst.req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("rst.ready_after_release", 32'(req_ready), 32'd1);

        // Basic word store/load and sub-word loads
        issue("sw10",  1'b1, 32'h10, 32'hDEADBEEF, F3_SW,  32'h0,        1'b0, 0);
        issue("lw10",  1'b0, 32'h10, 32'h0,        F3_LW,  32'hDEADBEEF, 1'b0, 0);
        issue("lb13",  1'b0, 32'h13, 32'h0,        F3_LB,  32'hFFFFFFDE, 1'b0, 0);
        issue("lbu13", 1'b0, 32'h13, 32'h0,        F3_LBU, 32'h000000DE, 1'b0, 0);
        issue("lh12",  1'b0, 32'h12, 32'h0,        F3_LH,  32'hFFFFDEAD, 1'b0, 0);
        issue("lhu10", 1'b0, 32'h10, 32'h0,        F3_LHU, 32'h0000BEEF, 1'b0, 0);

        // Byte store preserves neighbouring lanes
        issue("sb11",  1'b1, 32'h11, 32'h00000055, F3_SB,  32'h0,        1'b0, 0);
        issue("lw10b", 1'b0, 32'h10, 32'h0,        F3_LW,  32'hDEAD55EF, 1'b0, 0);

        // Illegal funct3 codes fault without writing
        issue("st011", 1'b1, 32'h10, 32'h12345678, 3'b011, 32'h0,        1'b1, 0);
        issue("st111", 1'b1, 32'h10, 32'h12345678, 3'b111, 32'h0,        1'b1, 0);
        issue("ld110", 1'b0, 32'h10, 32'h0,        3'b110, 32'h0,        1'b1, 0);
        issue("lw10c", 1'b0, 32'h10, 32'h0,        F3_LW,  32'hDEAD55EF, 1'b0, 0);

        // Response held for 5 cycles with a competing request, then taken
        issue("stall", 1'b0, 32'h10, 32'h0,        F3_LW,  32'hDEAD55EF, 1'b0, 5);
        issue("lw10d", 1'b0, 32'h10, 32'h0,        F3_LW,  32'hDEAD55EF, 1'b0, 0);

        // Misaligned accesses
`ifdef DMEM_MISALIGN_TRAP_EN
        issue("lw12",  1'b0, 32'h12, 32'h0,        F3_LW,  32'h0,        1'b1, 0);
        issue("sh13",  1'b1, 32'h13, 32'h0000ABCD, F3_SH,  32'h0,        1'b1, 0);
        word10 = 32'hDEAD55EF;
`else
        issue("lw12",  1'b0, 32'h12, 32'h0,        F3_LW,  32'hDEAD55EF, 1'b0, 0);
        issue("sh13",  1'b1, 32'h13, 32'h0000ABCD, F3_SH,  32'h0,        1'b0, 0);
        word10 = 32'hABCD55EF;
`endif
        issue("lw10e", 1'b0, 32'h10, 32'h0,        F3_LW,  word10,       1'b0, 0);

        // High address bits wrap onto the same word
        issue("sw_wrap", 1'b1, 32'h0000_1010, 32'h0BADF00D, F3_SW, 32'h0, 1'b0, 0);
        issue("lw_wrap", 1'b0, 32'h10,        32'h0,        F3_LW, 32'h0BADF00D, 1'b0, 0);

        // Random word store followed by a random unsigned byte read-back
        for (int i = 0; i < 6; i++) begin
            rnd_word = $urandom;
            rnd_addr = 32'h400 + 32'(4 * $urandom_range(0, 63));
            issue("rnd_sw", 1'b1, rnd_addr, rnd_word, F3_SW, 32'h0, 1'b0, 0);
            case (i % 4)
                0: issue("rnd_lbu", 1'b0, rnd_addr,      32'h0, F3_LBU, {24'h0, rnd_word[7:0]},   1'b0, 0);
                1: issue("rnd_lbu", 1'b0, rnd_addr + 1,  32'h0, F3_LBU, {24'h0, rnd_word[15:8]},  1'b0, 0);
                2: issue("rnd_lbu", 1'b0, rnd_addr + 2,  32'h0, F3_LBU, {24'h0, rnd_word[23:16]}, 1'b0, 0);
                default: issue("rnd_lbu", 1'b0, rnd_addr + 3, 32'h0, F3_LBU, {24'h0, rnd_word[31:24]}, 1'b0, 0);
            endcase
        end

        // Reset during WAIT discards a pending store
        issue("sw20",  1'b1, 32'h20, 32'hCAFEF00D, F3_SW, 32'h0,        1'b0, 0);
        issue("lw20",  1'b0, 32'h20, 32'h0,        F3_LW, 32'hCAFEF00D, 1'b0, 0);
        drive_req("sw20_abort", 1'b1, 32'h20, 32'h00000001, F3_SW);
        rst_n = 1'b0;
        #1;
        check("abort.rsp_rdata", rsp_rdata, 32'h0);
        check("abort.rsp_err", 32'(rsp_err), 32'd0);
        check("abort.req_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check("abort.rsp_valid_rst", 32'(rsp_valid), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 check("abort.rsp_valid_after", 32'(rsp_valid), 32'd0);
        end
        check("abort.ready_after", 32'(req_ready), 32'd1);
        issue("lw20b", 1'b0, 32'h20, 32'h0, F3_LW, 32'hCAFEF00D, 1'b0, 0);

        check("sb.empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends with its summary
    initial begin
        #200000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
